usr_cmd_sequencer: RTL and testbench
====================================

Name: usr_cmd_sequencer

Overview:
Command-driven controller that sits directly upstream of the 4-bit universal shift register and produces all of its control and data inputs: mode select, parallel data, serial fill bits and active-low clear. It accepts one command at a time over a valid/ready handshake (LOAD, SHIFT-RIGHT n, SHIFT-LEFT n, CLEAR) and sequences it cycle by cycle. It keeps a shadow copy of the register contents so software and checkers know the expected register value.

Parameters:
WIDTH, 4, register width; must match the downstream shift register.
CNT_W, 3, width of the shift-count field; must satisfy 2**CNT_W > WIDTH.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
Clear  input  1  reset; synchronous, active-high.
cmd_valid  input  1  command present.
cmd_ready  output  1  sequencer can accept a command this cycle.
cmd_op  input  2  00 LOAD, 01 SHR, 10 SHL, 11 CLEAR.
cmd_data  input  WIDTH  LOAD: parallel value. SHR/SHL: fill bits, consumed LSB first.
cmd_count  input  CNT_W  number of shift cycles for SHR/SHL; ignored for LOAD/CLEAR.
sel_line  output  2  to register: 00 hold, 01 shift right (MSB fill), 10 shift left (LSB fill), 11 parallel load.
par_data  output  WIDTH  to register parallel input.
msb_in  output  1  to register right-shift serial input.
lsb_in  output  1  to register left-shift serial input.
clear_b  output  1  to register clear, active-low.
busy  output  1  command in progress (state != IDLE).
done  output  1  one-cycle pulse when a command completes.
shadow  output  WIDTH  expected register contents.

Behaviour:
- All outputs are registered. States: IDLE, RUN, CLR, DONE.
- Reset while Clear=1:
  - State goes to IDLE.
  - sel_line=00, par_data=0, msb_in=0, lsb_in=0, done=0, busy=0, shadow=0.
  - clear_b=0, so the register is cleared together with the sequencer.
  - cmd_ready=0.
  - First cycle after Clear deasserts: clear_b=1, cmd_ready=1.
- Reset mid-command aborts the command immediately. No done pulse is produced.
- IDLE:
  - cmd_ready=1.
  - Accept on cmd_valid && cmd_ready. Latch op, data and count; cmd_ready drops on the next cycle.
- LOAD:
  - One RUN cycle: sel_line=11, par_data=cmd_data.
  - shadow<=cmd_data on the same edge the register loads.
- SHR n:
  - n RUN cycles with sel_line=01. On cycle k (k=0..n-1): msb_in=cmd_data[k].
  - Shadow update each edge: shadow<={msb_in, shadow[WIDTH-1:1]}.
- SHL n:
  - n RUN cycles with sel_line=10, lsb_in=cmd_data[k].
  - Shadow update each edge: shadow<={shadow[WIDTH-2:0], lsb_in}.
- Shift count rules:
  - n > WIDTH saturates to WIDTH.
  - n=0 skips RUN and goes directly to DONE; sel_line stays 00 and shadow is unchanged.
- CLEAR:
  - One CLR cycle: clear_b=0, sel_line=00.
  - shadow<=0.
- DONE:
  - Exactly one cycle: done=1, sel_line=00, cmd_ready=0.
  - Next state is IDLE.
- Outside RUN: sel_line=00 (hold) and msb_in/lsb_in=0.
- Command latency and back-to-back rate:
  - Acceptance edge to done: n+1 cycles for shifts, 2 cycles for LOAD/CLEAR, 1 cycle for n=0.
  - Minimum spacing between accepts is n+2 cycles, because DONE and IDLE each take one cycle.
- cmd_valid while busy is ignored. The upstream holds the command stable until cmd_ready is sampled high.
- busy=1 in RUN, CLR and DONE.

Optional Feature:
Macro: USR_SHADOW_CHECK_EN.
- Defined, additional ports:
  - usr_q (input, WIDTH): the register output.
  - chk_err (output, 1): sticky error flag.
- Defined, check behaviour:
  - Every cycle, usr_q is compared to shadow. The comparison is skipped while Clear=1 and on the first cycle after Clear deasserts.
  - Any mismatch sets chk_err=1. chk_err clears only on Clear.
- Not defined: the ports do not exist, there is no comparison logic, and all other behaviour is identical.

Test Plan:
- Reset then LOAD 4'b1011 -> one cycle sel_line=11, par_data=1011; done 2 cycles after accept; shadow=1011; cmd_ready returns high 1 cycle after done.
- From shadow=1011, SHR count=2 with cmd_data=4'b0001 -> sel_line=01 for 2 cycles with msb_in=1 then 0; shadow 1101 then 0110; done at cycle 3.
- From shadow=0110, SHL count=7 (saturates to 4) with cmd_data=4'b1010 -> 4 cycles sel_line=10 with lsb_in 0,1,0,1; shadow=0101.
- SHR count=0 -> done 1 cycle after accept; sel_line stays 00; shadow unchanged. Then CLEAR -> clear_b=0 for exactly 1 cycle; shadow=0000.
- Assert Clear during cycle 2 of SHR count=4 -> next edge: sel_line=00, clear_b=0, busy=0, no done pulse; cmd_ready=1 one cycle after Clear drops.
- With USR_SHADOW_CHECK_EN: connect a real register, run mixed commands -> chk_err stays 0. Force usr_q bit 0 wrong for one cycle -> chk_err=1 and holds until Clear.

Source files
------------

// File: rtl/usr_cmd_sequencer_if.sv
// Command and register-control bundle between the upstream source, usr_cmd_sequencer
// and the downstream shift register. usr_q/chk_err exist only with USR_SHADOW_CHECK_EN.
interface usr_cmd_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic [1:0]       sel_line;
  logic [WIDTH-1:0] par_data;
  logic             msb_in;
  logic             lsb_in;
  logic             clear_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] shadow;
`ifdef USR_SHADOW_CHECK_EN
  logic [WIDTH-1:0] usr_q;
  logic             chk_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_count, usr_q,
    input  cmd_ready, sel_line, par_data, msb_in, lsb_in, clear_b, busy, done, shadow,
           chk_err
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_count, usr_q,
    output cmd_ready, sel_line, par_data, msb_in, lsb_in, clear_b, busy, done, shadow,
           chk_err
  );
`else
  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_count,
    input  cmd_ready, sel_line, par_data, msb_in, lsb_in, clear_b, busy, done, shadow
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_count,
    output cmd_ready, sel_line, par_data, msb_in, lsb_in, clear_b, busy, done, shadow
  );
`endif
endinterface

// File: rtl/usr_cmd_sequencer.sv
// Sequences LOAD/SHR/SHL/CLEAR commands into universal-shift-register controls and
// tracks a shadow of its contents. Optional shadow checker: USR_SHADOW_CHECK_EN.
module usr_cmd_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input logic                CLK,
  input logic                Clear,
  usr_cmd_sequencer_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_CLR = 2'd2, S_DONE = 2'd3;
  localparam logic [1:0] OP_LOAD = 2'd0, OP_SHR = 2'd1, OP_SHL = 2'd2, OP_CLR = 2'd3;
  localparam logic [1:0] SEL_HOLD = 2'd0, SEL_SHR = 2'd1, SEL_SHL = 2'd2, SEL_LOAD = 2'd3;

  logic [1:0]       r_state, r_op, r_sel;
  logic [WIDTH-1:0] r_fill, r_par, r_shadow;
  logic [CNT_W-1:0] r_cnt;
  logic             r_msb, r_lsb, r_clear_b, r_busy, r_done, r_ready;
  logic             w_accept;
  logic [CNT_W-1:0] w_nsat;

  assign w_accept = bus.cmd_valid && r_ready;
  assign w_nsat   = (bus.cmd_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.cmd_count;

  always_ff @(posedge CLK) begin
    if (Clear) begin
      r_state   <= S_IDLE;
      r_op      <= OP_LOAD;
      r_sel     <= SEL_HOLD;
      r_fill    <= '0;
      r_par     <= '0;
      r_shadow  <= '0;
      r_cnt     <= '0;
      r_msb     <= 1'b0;
      r_lsb     <= 1'b0;
      r_clear_b <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      r_sel     <= SEL_HOLD;
      r_par     <= '0;
      r_msb     <= 1'b0;
      r_lsb     <= 1'b0;
      r_clear_b <= 1'b1;
      r_done    <= 1'b0;

      // Shadow follows what the register does on this same edge.
      if (!r_clear_b) r_shadow <= '0;
      else begin
        unique case (r_sel)
          SEL_SHR:  r_shadow <= {r_msb, r_shadow[WIDTH-1:1]};
          SEL_SHL:  r_shadow <= {r_shadow[WIDTH-2:0], r_lsb};
          SEL_LOAD: r_shadow <= r_par;
          default:  r_shadow <= r_shadow;
        endcase
      end

      unique case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          if (w_accept) begin
            r_op    <= bus.cmd_op;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            unique case (bus.cmd_op)
              OP_LOAD: begin
                r_state <= S_RUN;
                r_sel   <= SEL_LOAD;
                r_par   <= bus.cmd_data;
                r_cnt   <= '0;
              end
              OP_CLR: begin
                r_state   <= S_CLR;
                r_clear_b <= 1'b0;
              end
              default: begin
                if (w_nsat == '0) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                end else begin
                  // Fill bits are consumed LSB first; keep the rest pre-shifted.
                  r_state <= S_RUN;
                  r_sel   <= (bus.cmd_op == OP_SHR) ? SEL_SHR : SEL_SHL;
                  r_msb   <= (bus.cmd_op == OP_SHR) & bus.cmd_data[0];
                  r_lsb   <= (bus.cmd_op == OP_SHL) & bus.cmd_data[0];
                  r_fill  <= bus.cmd_data >> 1;
                  r_cnt   <= w_nsat - CNT_W'(1);
                end
              end
            endcase
          end
        end
        S_RUN: begin
          if (r_cnt == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_sel  <= r_sel;
            r_msb  <= (r_op == OP_SHR) & r_fill[0];
            r_lsb  <= (r_op == OP_SHL) & r_fill[0];
            r_fill <= r_fill >> 1;
            r_cnt  <= r_cnt - CNT_W'(1);
          end
        end
        S_CLR: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = r_ready;
  assign bus.sel_line  = r_sel;
  assign bus.par_data  = r_par;
  assign bus.msb_in    = r_msb;
  assign bus.lsb_in    = r_lsb;
  assign bus.clear_b   = r_clear_b;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.shadow    = r_shadow;

`ifdef USR_SHADOW_CHECK_EN
  logic r_chk_arm, r_chk_err;

  // Arming one cycle late skips the edge where the register may still be stale.
  always_ff @(posedge CLK) begin
    if (Clear) begin
      r_chk_arm <= 1'b0;
      r_chk_err <= 1'b0;
    end else begin
      r_chk_arm <= 1'b1;
      if (r_chk_arm && (bus.usr_q != r_shadow)) r_chk_err <= 1'b1;
    end
  end

  assign bus.chk_err = r_chk_err;
`endif
endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Self-checking bench for usr_cmd_sequencer: directed plan, random commands,
// back-to-back issue, mid-command abort, and the optional shadow checker.
module tb_usr_cmd_sequencer;
  localparam int W = 4;
  localparam logic [1:0] LOAD = 2'd0, SHR = 2'd1, SHL = 2'd2, CLR = 2'd3;

  logic CLK;
  logic Clear;
  int   checks, errors;
  logic [W-1:0] m_sh;

  usr_cmd_sequencer_if #(.WIDTH(W), .CNT_W(3)) bus ();

  usr_cmd_sequencer #(.WIDTH(W), .CNT_W(3)) dut (
    .CLK  (CLK),
    .Clear(Clear),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

`ifdef USR_SHADOW_CHECK_EN
  logic [W-1:0] r_q;
  logic         inj;
  always @(posedge CLK) begin
    if (!bus.clear_b) r_q <= '0;
    else begin
      case (bus.sel_line)
        2'd1:    r_q <= {bus.msb_in, r_q[W-1:1]};
        2'd2:    r_q <= {r_q[W-2:0], bus.lsb_in};
        2'd3:    r_q <= bus.par_data;
        default: r_q <= r_q;
      endcase
    end
  end
  assign bus.usr_q = r_q ^ {{(W-1){1'b0}}, inj};
`endif

  // {sel_line, msb_in, lsb_in, clear_b, busy, done, cmd_ready}
  function automatic logic [7:0] obs();
    return {bus.sel_line, bus.msb_in, bus.lsb_in, bus.clear_b, bus.busy, bus.done, bus.cmd_ready};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] data,
                        input logic [2:0] cnt, input bit noisy);
    int n, waited;
    logic [W-1:0] fill;
    logic [7:0] exp_v;
    logic b;
    waited = 0;
    while (bus.cmd_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait got %b want 1", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_count = cnt;
    tick();
    bus.cmd_valid = noisy;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_data  = W'($urandom);
    bus.cmd_count = 3'($urandom);
    if (op == LOAD || op == CLR) n = 1;
    else n = (cnt > 3'(W)) ? W : int'(cnt);
    fill = data;
    for (int k = 0; k < n; k++) begin
      b = fill[0];
      fill = fill >> 1;
      case (op)
        LOAD:    exp_v = 8'b11_0_0_1_1_0_0;
        SHR:     exp_v = {2'b01, b, 1'b0, 4'b1100};
        SHL:     exp_v = {2'b10, 1'b0, b, 4'b1100};
        default: exp_v = 8'b00_0_0_0_1_0_0;
      endcase
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL run op=%0d k=%0d got %b want %b", op, k, obs(), exp_v);
      end
      if (op == LOAD) begin
        checks++;
        if (bus.par_data !== data) begin
          errors++;
          $display("FAIL par_data got %b want %b", bus.par_data, data);
        end
      end
      case (op)
        LOAD:    m_sh = data;
        SHR:     m_sh = {b, m_sh[W-1:1]};
        SHL:     m_sh = {m_sh[W-2:0], b};
        default: m_sh = '0;
      endcase
      if (noisy) begin
        bus.cmd_op   = 2'($urandom);
        bus.cmd_data = W'($urandom);
      end
      tick();
      checks++;
      if (bus.shadow !== m_sh) begin
        errors++;
        $display("FAIL shadow_step op=%0d k=%0d got %b want %b", op, k, bus.shadow, m_sh);
      end
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (obs() !== 8'b00_0_0_1_1_1_0) begin
      errors++;
      $display("FAIL done_cycle op=%0d got %b want %b", op, obs(), 8'b00001110);
    end
    tick();
    checks++;
    if (obs() !== 8'b00_0_0_1_0_0_1 || bus.shadow !== m_sh) begin
      errors++;
      $display("FAIL idle_after op=%0d got %b/%b want %b/%b", op, obs(), bus.shadow,
               8'b00001001, m_sh);
    end
  endtask

  task automatic test_reset();
    Clear = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'd0;
    bus.cmd_data = '0;
    bus.cmd_count = '0;
    repeat (3) tick();
    checks++;
    if (obs() !== 8'b0 || bus.shadow !== '0 || bus.par_data !== '0) begin
      errors++;
      $display("FAIL reset_state got %b/%b/%b want 0", obs(), bus.shadow, bus.par_data);
    end
    Clear = 1'b0;
    tick();
    checks++;
    if (obs() !== 8'b00_0_0_1_0_0_1) begin
      errors++;
      $display("FAIL reset_release got %b want %b", obs(), 8'b00001001);
    end
    m_sh = '0;
  endtask

  task automatic test_plan();
    do_cmd(LOAD, 4'b1011, 3'd0, 1'b0);
    checks++;
    if (bus.shadow !== 4'b1011) begin
      errors++;
      $display("FAIL plan_load got %b want 1011", bus.shadow);
    end
    do_cmd(SHR, 4'b0001, 3'd2, 1'b0);
    checks++;
    if (bus.shadow !== 4'b0110) begin
      errors++;
      $display("FAIL plan_shr got %b want 0110", bus.shadow);
    end
    do_cmd(SHL, 4'b1010, 3'd7, 1'b0);
    checks++;
    if (bus.shadow !== 4'b0101) begin
      errors++;
      $display("FAIL plan_shl got %b want 0101", bus.shadow);
    end
    do_cmd(SHR, 4'b1111, 3'd0, 1'b0);
    do_cmd(CLR, 4'b1111, 3'd3, 1'b0);
    checks++;
    if (bus.shadow !== 4'b0000) begin
      errors++;
      $display("FAIL plan_clear got %b want 0000", bus.shadow);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++)
      do_cmd(2'($urandom), W'($urandom), 3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++)
      do_cmd(2'($urandom), W'($urandom), 3'($urandom_range(0, 7)), 1'b1);
  endtask

  task automatic test_abort();
    do_cmd(LOAD, W'($urandom), 3'd0, 1'b0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = SHR;
    bus.cmd_data  = W'($urandom);
    bus.cmd_count = 3'd4;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    Clear = 1'b1;
    tick();
    checks++;
    if (obs() !== 8'b0 || bus.shadow !== '0) begin
      errors++;
      $display("FAIL abort_state got %b/%b want 0/0", obs(), bus.shadow);
    end
    Clear = 1'b0;
    tick();
    checks++;
    if (obs() !== 8'b00_0_0_1_0_0_1) begin
      errors++;
      $display("FAIL abort_release got %b want %b", obs(), 8'b00001001);
    end
    m_sh = '0;
    do_cmd(SHL, 4'b0110, 3'd3, 1'b0);
  endtask

`ifdef USR_SHADOW_CHECK_EN
  task automatic test_shadow_check();
    checks++;
    if (bus.chk_err !== 1'b0) begin
      errors++;
      $display("FAIL chk_clean got %b want 0", bus.chk_err);
    end
    inj = 1'b1;
    tick();
    inj = 1'b0;
    checks++;
    if (bus.chk_err !== 1'b1) begin
      errors++;
      $display("FAIL chk_set got %b want 1", bus.chk_err);
    end
    do_cmd(LOAD, 4'b1001, 3'd0, 1'b0);
    checks++;
    if (bus.chk_err !== 1'b1) begin
      errors++;
      $display("FAIL chk_sticky got %b want 1", bus.chk_err);
    end
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    tick();
    m_sh = '0;
    checks++;
    if (bus.chk_err !== 1'b0) begin
      errors++;
      $display("FAIL chk_cleared got %b want 0", bus.chk_err);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
`ifdef USR_SHADOW_CHECK_EN
    inj = 1'b0;
`endif
    test_reset();
    test_plan();
    test_random();
    test_back_to_back();
    test_abort();
`ifdef USR_SHADOW_CHECK_EN
    test_random();
    test_shadow_check();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
